// File: rtl/dbus_wb_master_pkg.sv
// ---------------------------------------------------------------------------
// dbus_wb_master_pkg
//   Shared definitions for the mem-stage to Wishbone bridge: FSM state
//   encoding, default timeout configuration and the pipeline-level
//   enable/reset polarities used by the surrounding CPU.
// ---------------------------------------------------------------------------
package dbus_wb_master_pkg;

    // Bridge FSM, 2-bit encoding.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,   // waiting for a mem-stage request
        ST_BUSY       = 2'd1,   // Wishbone cycle in flight
        ST_WAIT_STALL = 2'd2    // access done, pipeline still held elsewhere
    } state_e;

    // Default bus timeout (BUSY cycles without ack); 0 disables the timeout.
    localparam int TIMEOUT_DEFAULT = 255;
    localparam int CNT_W_DEFAULT   = 8;

    // Pipeline-level polarities.
    localparam logic CHIP_ENABLE = 1'b1;
    localparam logic RST_ENABLE  = 1'b1;

    // True when the timeout counter has reached its final BUSY cycle.
    function automatic logic timeout_hit(input int cnt, input int limit);
        return (limit != 0) && (cnt == limit - 1);
    endfunction

endpackage

// File: rtl/dbus_wb_master.sv
// ---------------------------------------------------------------------------
// dbus_wb_master
//   Bridges the mem stage's single-cycle data-RAM request onto a Wishbone B3
//   classic master port. The pipeline is held through stallreq_o until the
//   slave acks; read data is buffered for as long as another requester keeps
//   the pipeline stalled after the access has completed. A flush or a bus
//   timeout aborts the cycle.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   stall_i[5:0]     ctrl stall vector {wb,mem,ex,id,if,pc}
//   flush_i          exception flush
//   cpu_ce_i         mem-stage request valid
//   cpu_we_i         1 = store, 0 = load
//   cpu_addr_i       byte address
//   cpu_sel_i        byte lanes (bit3 = bits[31:24])
//   cpu_data_i       store data (lane-replicated)
//   cpu_data_o       load data back to mem stage
//   stallreq_o       hold pipeline, access not complete
//   bus_err_o        one-cycle pulse on timeout abort
//   wb_*             Wishbone classic master signals
// ---------------------------------------------------------------------------
module dbus_wb_master
    import dbus_wb_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        bus_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i
);

    state_e            state_q, state_d;
    logic [31:0]       adr_q, adr_d;
    logic [31:0]       dat_q, dat_d;
    logic              we_q, we_d;
    logic [3:0]        sel_q, sel_d;
    logic              stb_q, stb_d;
    logic              cyc_q, cyc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rd_buf_q, rd_buf_d;
    logic              bus_err_q, bus_err_d;
    logic              timeout_now;

    assign timeout_now = timeout_hit(int'(cnt_q), TIMEOUT_CYCLES);

    // Next-state and combinational outputs.
    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        sel_d      = sel_q;
        stb_d      = stb_q;
        cyc_d      = cyc_q;
        cnt_d      = cnt_q;
        rd_buf_d   = rd_buf_q;
        bus_err_d  = 1'b0;
        stallreq_o = 1'b0;
        cpu_data_o = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_ce_i == CHIP_ENABLE && !flush_i) begin
                    // Capture the request; cpu_* is not looked at again
                    // until the bridge returns here.
                    adr_d      = cpu_addr_i;
                    dat_d      = cpu_data_i;
                    we_d       = cpu_we_i;
                    sel_d      = cpu_sel_i;
                    stb_d      = 1'b1;
                    cyc_d      = 1'b1;
                    cnt_d      = '0;
                    stallreq_o = 1'b1;
                    state_d    = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (flush_i) begin
                    // Flush wins over a same-cycle ack: the instruction
                    // is being discarded, so its data is too.
                    stb_d    = 1'b0;
                    cyc_d    = 1'b0;
                    we_d     = 1'b0;
                    sel_d    = 4'd0;
                    rd_buf_d = 32'd0;
                    state_d  = ST_IDLE;
                end else if (wb_ack_i) begin
                    // Release the pipeline in the ack cycle itself and pass
                    // the load data straight through.
                    cpu_data_o = we_q ? 32'd0 : wb_dat_i;
                    stb_d      = 1'b0;
                    cyc_d      = 1'b0;
                    we_d       = 1'b0;
                    sel_d      = 4'd0;
                    if (!we_q) begin
                        rd_buf_d = wb_dat_i;
                    end
                    state_d = (stall_i != 6'd0) ? ST_WAIT_STALL : ST_IDLE;
                end else if (timeout_now) begin
                    stallreq_o = 1'b1;
                    stb_d      = 1'b0;
                    cyc_d      = 1'b0;
                    we_d       = 1'b0;
                    sel_d      = 4'd0;
                    rd_buf_d   = 32'd0;
                    bus_err_d  = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    stallreq_o = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end
            end

            ST_WAIT_STALL: begin
                // Keep presenting the load result while another stage
                // holds the pipeline; no new bus cycle is started here.
                cpu_data_o = rd_buf_q;
                if (flush_i) begin
                    rd_buf_d = 32'd0;
                    state_d  = ST_IDLE;
                end else if (stall_i == 6'd0) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q   <= ST_IDLE;
            adr_q     <= 32'd0;
            dat_q     <= 32'd0;
            we_q      <= 1'b0;
            sel_q     <= 4'd0;
            stb_q     <= 1'b0;
            cyc_q     <= 1'b0;
            cnt_q     <= '0;
            rd_buf_q  <= 32'd0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            stb_q     <= stb_d;
            cyc_q     <= cyc_d;
            cnt_q     <= cnt_d;
            rd_buf_q  <= rd_buf_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_we_o   = we_q;
    assign wb_sel_o  = sel_q;
    assign wb_stb_o  = stb_q;
    assign wb_cyc_o  = cyc_q;
    assign bus_err_o = bus_err_q;

endmodule
